conv_enc_frame_ctrl: RTL and testbench
======================================

# conv_enc_frame_ctrl

Frame sequencer wrapped around a rate-1/2, constraint-length-3 convolutional encoder. It accepts bytes over a valid/ready stream and encodes each byte bit-serially, MSB first, into one 16-bit codeword. At frame end it appends a zero-flush tail codeword that returns the encoder to the all-zero state. It sits between the byte-stream source and the modulator/interleaver, and replaces free-running, unframed use of the encoder.

## Interface
- G0, 3'b111, generator polynomial for the first coded bit (octal 7); bit 2 taps the current input
- G1, 3'b101, generator polynomial for the second coded bit (octal 5)
- TAIL_EN, 1, 1 = append a tail codeword after in_last; 0 = no tail, encoder state cleared at frame end
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- in_data  in  8  byte to encode
- in_valid  in  1  in_data valid
- in_last  in  1  byte is the last of the frame; sampled with the handshake
- in_ready  out  1  block can accept a byte
- out_data  out  16  codeword
- out_valid  out  1  out_data valid
- out_last  out  1  codeword is the final one of the frame
- out_ready  in  1  sink accepts the codeword
- busy  out  1  high in any state other than IDLE
- frame_count  out  16  frames completed; wraps 0xFFFF -> 0x0000

## Operation
- Encoder state is s[1:0]: s[1] holds the previous bit, s[0] the bit before that. For input bit u, w = {u, s[1], s[0]}; c0 = ^(w & G0); c1 = ^(w & G1); then s <= {u, s[1]}.
- Bit i of a byte (i = 0 is in_data[7]) produces out_data[15-2i] = c0 and out_data[14-2i] = c1.
- State machine states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch the byte and in_last, clear the bit counter, and go to ENC.
  - ENC: one bit per cycle, 3-bit counter 0..7. After count 7, go to OUT.
  - OUT: out_valid = 1, with out_data and out_last stable. On out_ready:
    - word was tail → IDLE
    - latched last & TAIL_EN → TAIL
    - latched last & !TAIL_EN → IDLE, with s cleared
    - otherwise → IDLE, with s preserved
  - TAIL: encode 8 zero bits, 8 cycles, same counter. Go to OUT with out_last = 1.
- s carries across bytes within a frame. s is all-zero at the start of every frame, guaranteed by the tail or by the explicit clear.
- out_last = 1 only on the final codeword of a frame: the tail word if TAIL_EN, otherwise the last data word.
- frame_count increments on the out_valid & out_ready handshake of the codeword with out_last = 1.
- in_valid while in_ready = 0 is ignored. in_data and in_last are not sampled outside IDLE.

## Timing
- Reset values: in_ready 0 during the reset cycle, 1 from the first cycle after reset is released; out_valid 0; out_last 0; out_data 0x0000; busy 0; frame_count 0; s 2'b00; state IDLE.
- Latency: byte handshake at edge N → out_valid asserted after edge N+8.
- Throughput: with out_ready held high, one byte per 10 cycles (1 IDLE + 8 ENC + 1 OUT). The tail adds 9 cycles per frame.
- Backpressure: OUT holds indefinitely while out_ready = 0. out_data and out_last must not change while out_valid = 1 and out_ready = 0.
- in_ready and out_valid are never both 1.
- reset asserted in any state (including mid-ENC and mid-TAIL) takes effect on the next edge and returns to the reset values. A partial word is discarded and frame_count is unchanged.
- Single-byte frames are legal.

## Test plan
- Single byte 0xAA with in_last, TAIL_EN = 1, out_ready = 1 → codewords 0xE222 then 0xC000 (out_last = 1), frame_count = 1. out_valid first rises 8 cycles after the handshake.
- Frame 0xAA, then 0xCC with in_last → 0xE222, 0x17D7, 0x0000 (out_last on 0x0000 only). The result confirms that state carries across bytes.
- Back-to-back single-byte frames 0xCC and 0xCC → 0xD7D7/0x0000 for each frame (identical, state reset between frames), frame_count = 2.
- out_ready held 0 for 5 cycles during OUT → out_data stays 0xE222, in_ready stays 0, and no byte is accepted despite in_valid = 1.
- TAIL_EN = 0, byte 0xAA with in_last → single word 0xE222 with out_last = 1. A following 0xCC frame yields 0xD7D7, confirming s was cleared.
- reset pulsed at ENC count 4 → next cycle all outputs are at reset values. A subsequent 0xAA frame yields 0xE222 and 0xC000, and frame_count = 1.

Source files
------------

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer around a rate-1/2, K=3 convolutional encoder: one byte in, one 16-bit codeword
// out (MSB first), with an optional zero-flush tail codeword at frame end.
module conv_enc_frame_ctrl #(
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101,
  parameter bit         TAIL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {StIdle, StEnc, StOut, StTail} state_e;

  state_e      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        tail_q, tail_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  s_q, s_d;
  logic [15:0] word_q, word_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic       u;
  logic [2:0] w;
  logic       c0, c1;
  logic       word_last;

  always_comb begin
    // Tail bits are zeros; data bits come from the top of the byte shifter
    u         = (state_q == StEnc) ? byte_q[7] : 1'b0;
    w         = {u, s_q};
    c0        = ^(w & G0);
    c1        = ^(w & G1);
    word_last = tail_q | (last_q & !TAIL_EN);

    state_d       = state_q;
    byte_d        = byte_q;
    last_d        = last_q;
    tail_d        = tail_q;
    cnt_d         = cnt_q;
    s_d           = s_q;
    word_d        = word_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          byte_d  = in_data;
          last_d  = in_last;
          cnt_d   = 3'd0;
          state_d = StEnc;
        end
      end
      StEnc, StTail: begin
        s_d    = {u, s_q[1]};
        word_d = {word_q[13:0], c0, c1};
        byte_d = {byte_q[6:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (word_last) frame_count_d = frame_count_q + 16'd1;
          if (tail_q) begin
            tail_d  = 1'b0;
            state_d = StIdle;
          end else if (last_q && TAIL_EN) begin
            tail_d  = 1'b1;
            cnt_d   = 3'd0;
            state_d = StTail;
          end else begin
            if (last_q) s_d = 2'b00;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      byte_q        <= 8'h00;
      last_q        <= 1'b0;
      tail_q        <= 1'b0;
      cnt_q         <= 3'd0;
      s_q           <= 2'b00;
      word_q        <= 16'h0000;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      s_q           <= s_d;
      word_q        <= word_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in_ready    = (state_q == StIdle) && !reset;
  assign out_valid   = (state_q == StOut);
  assign out_last    = out_valid && word_last;
  assign out_data    = word_q;
  assign busy        = (state_q != StIdle);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl: instance a with tail flush, instance b without.
module tb_conv_enc_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  in_data;
  logic        in_last;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_ready, a_busy;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_ready, b_busy;
  logic [15:0] a_out_data, a_frame_count, b_out_data, b_frame_count;

  int passed = 0;
  int total  = 0;

  conv_enc_frame_ctrl #(.G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(a_in_valid), .in_last(in_last),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_ready(a_out_ready), .busy(a_busy), .frame_count(a_frame_count)
  );

  conv_enc_frame_ctrl #(.G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(b_in_valid), .in_last(in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_ready(b_out_ready), .busy(b_busy), .frame_count(b_frame_count)
  );

  // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
  task automatic send(input bit sel, input logic [7:0] d, input logic l);
    int cyc = 0;
    in_data = d;
    in_last = l;
    if (sel) b_in_valid = 1'b1; else a_in_valid = 1'b1;
    while (!(sel ? b_in_ready : a_in_ready) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // Waits for out_valid (bounded), captures the word, then steps one falling edge.
  task automatic get_word(input bit sel, output logic [15:0] d, output logic l, output int cyc);
    cyc = 0;
    while (!(sel ? b_out_valid : a_out_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      d = 16'hxxxx;
      l = 1'bx;
    end else begin
      d = sel ? b_out_data : a_out_data;
      l = sel ? b_out_last : a_out_last;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", a_in_ready); else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", a_out_valid); else passed++;
    total++; if (a_out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", a_out_last); else passed++;
    total++; if (a_out_data !== 16'h0000) $display("FAIL rst_out_data: got %h want 0000", a_out_data); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", a_busy); else passed++;
    total++; if (a_frame_count !== 16'h0000) $display("FAIL rst_frame_count: got %h want 0000", a_frame_count); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (a_in_ready !== 1'b1) $display("FAIL rst_release_in_ready: got %b want 1", a_in_ready); else passed++;
  endtask

  task automatic test_single_byte;
    logic [15:0] d; logic l; int cyc;
    send(1'b0, 8'hAA, 1'b1);
    get_word(1'b0, d, l, cyc);
    total++; if (cyc !== 8) $display("FAIL single_latency: got %0d want 8", cyc); else passed++;
    total++; if (d !== 16'hE222) $display("FAIL single_word0: got %h want e222", d); else passed++;
    total++; if (l !== 1'b0) $display("FAIL single_last0: got %b want 0", l); else passed++;
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'hC000) $display("FAIL single_tail: got %h want c000", d); else passed++;
    total++; if (l !== 1'b1) $display("FAIL single_tail_last: got %b want 1", l); else passed++;
    total++; if (a_frame_count !== 16'd1) $display("FAIL single_count: got %0d want 1", a_frame_count); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL single_idle: got busy %b want 0", a_busy); else passed++;
  endtask

  task automatic test_two_byte_frame;
    logic [15:0] d; logic l; int cyc;
    send(1'b0, 8'hAA, 1'b0);
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'hE222 || l !== 1'b0) $display("FAIL two_w0: got %h/%b want e222/0", d, l); else passed++;
    send(1'b0, 8'hCC, 1'b1);
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'h17D7 || l !== 1'b0) $display("FAIL two_w1: got %h/%b want 17d7/0", d, l); else passed++;
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'h0000 || l !== 1'b1) $display("FAIL two_tail: got %h/%b want 0000/1", d, l); else passed++;
    total++; if (a_frame_count !== 16'd2) $display("FAIL two_count: got %0d want 2", a_frame_count); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d; logic l; int cyc;
    for (int f = 0; f < 2; f++) begin
      send(1'b0, 8'hCC, 1'b1);
      get_word(1'b0, d, l, cyc);
      total++; if (d !== 16'hD7D7 || l !== 1'b0) $display("FAIL b2b_w%0d: got %h/%b want d7d7/0", f, d, l); else passed++;
      get_word(1'b0, d, l, cyc);
      total++; if (d !== 16'h0000 || l !== 1'b1) $display("FAIL b2b_tail%0d: got %h/%b want 0000/1", f, d, l); else passed++;
    end
    total++; if (a_frame_count !== 16'd4) $display("FAIL b2b_count: got %0d want 4", a_frame_count); else passed++;
  endtask

  task automatic test_backpressure;
    logic [15:0] d; logic l; int cyc;
    a_out_ready = 1'b0;
    send(1'b0, 8'hAA, 1'b1);
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'hE222) $display("FAIL bp_word: got %h want e222", d); else passed++;
    in_data    = 8'h55;
    in_last    = 1'b1;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (a_out_data !== 16'hE222 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
        $display("FAIL bp_hold%0d: got data %h rdy %b vld %b want e222 0 1", i, a_out_data, a_in_ready, a_out_valid);
      else passed++;
      @(negedge clk);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'hC000 || l !== 1'b1) $display("FAIL bp_tail: got %h/%b want c000/1", d, l); else passed++;
    repeat (3) @(negedge clk);
    total++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) $display("FAIL bp_no_accept: got busy %b vld %b want 0 0", a_busy, a_out_valid); else passed++;
    total++; if (a_frame_count !== 16'd5) $display("FAIL bp_count: got %0d want 5", a_frame_count); else passed++;
  endtask

  task automatic test_no_tail;
    logic [15:0] d; logic l; int cyc;
    send(1'b1, 8'hAA, 1'b1);
    get_word(1'b1, d, l, cyc);
    total++; if (d !== 16'hE222 || l !== 1'b1) $display("FAIL notail_w0: got %h/%b want e222/1", d, l); else passed++;
    send(1'b1, 8'hCC, 1'b1);
    get_word(1'b1, d, l, cyc);
    total++; if (d !== 16'hD7D7 || l !== 1'b1) $display("FAIL notail_w1: got %h/%b want d7d7/1", d, l); else passed++;
    total++; if (b_frame_count !== 16'd2) $display("FAIL notail_count: got %0d want 2", b_frame_count); else passed++;
  endtask

  task automatic test_reset_mid_enc;
    logic [15:0] d; logic l; int cyc;
    send(1'b0, 8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (a_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", a_busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_data !== 16'h0000
        || a_busy !== 1'b0 || a_frame_count !== 16'h0000)
      $display("FAIL mid_reset_vals: got rdy %b vld %b last %b data %h busy %b cnt %h want 0 0 0 0000 0 0000",
               a_in_ready, a_out_valid, a_out_last, a_out_data, a_busy, a_frame_count);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    send(1'b0, 8'hAA, 1'b1);
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'hE222 || l !== 1'b0) $display("FAIL mid_after_w0: got %h/%b want e222/0", d, l); else passed++;
    get_word(1'b0, d, l, cyc);
    total++; if (d !== 16'hC000 || l !== 1'b1) $display("FAIL mid_after_tail: got %h/%b want c000/1", d, l); else passed++;
    total++; if (a_frame_count !== 16'd1) $display("FAIL mid_after_count: got %0d want 1", a_frame_count); else passed++;
  endtask

  initial begin
    reset       = 1'b1;
    in_data     = 8'h00;
    in_last     = 1'b0;
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(negedge clk);
    test_reset;
    test_single_byte;
    test_two_byte_frame;
    test_back_to_back;
    test_backpressure;
    test_no_tail;
    test_reset_mid_enc;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
